// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multiport register file: DEPTH words of WIDTH bits shared by NPORTS
//   independent read/write ports. Register 0 doubles as a cascadable up-counter
//   and the eq flag compares register 0 with the top register.
//
// Parameters
//   WIDTH   bits per word (>= 2)
//   DEPTH   number of words (power of two, >= 2)
//   NPORTS  number of access ports (1..8)
//
// Ports
//   clk       rising-edge clock for all state
//   reset     synchronous, active-high; dominates writes, reads and counting
//   en        per-port enable (bit p = port p)
//   we, re    per-port write / read request, qualified by en
//   addr      port p address in [p*AW +: AW]
//   wdata     port p write data in [p*WIDTH +: WIDTH]
//   rdata     port p registered read data (holds when not reading)
//   rvalid    per-port read-result strobe
//   ci        count enable / carry in for register 0
//   co        carry out = ci & (R0 == all ones), combinational
//   eq        registered R0 == R[DEPTH-1], taken from post-edge contents
//   conflict  one-cycle pulse after two or more ports wrote one address
//
// Build option
//   REGFILE_MP_BYPASS_EN  when defined, a read returns the value its address
//                         will hold after the edge (winning write data or the
//                         incremented counter). Default: pre-edge contents.
//
// Read handshake: a read issued in cycle N (en[p] & re[p]) produces
// rvalid[p]=1 together with its data in rdata[p] during cycle N+1. There is
// no back-pressure; a cycle without a read leaves rvalid[p]=0 and rdata[p]
// unchanged. Reset discards any read issued in the same cycle.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter  int WIDTH  = 4,
  parameter  int DEPTH  = 4,
  parameter  int NPORTS = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       en,
  input  logic [NPORTS-1:0]       we,
  input  logic [NPORTS-1:0]       re,
  input  logic [NPORTS*AW-1:0]    addr,
  input  logic [NPORTS*WIDTH-1:0] wdata,
  output logic [NPORTS*WIDTH-1:0] rdata,
  output logic [NPORTS-1:0]       rvalid,
  input  logic                    ci,
  output logic                    co,
  output logic                    eq,
  output logic                    conflict
);

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] nextMem  [DEPTH];
  logic [WIDTH-1:0] readView [DEPTH];

  logic [AW-1:0]    portAddr  [NPORTS];
  logic [WIDTH-1:0] portWdata [NPORTS];
  logic [NPORTS-1:0] wrEn;
  logic [NPORTS-1:0] rdEn;

  logic [DEPTH-1:0] wrHit;
  logic             conflictNext;

  assign wrEn = en & we;
  assign rdEn = en & re;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      portAddr[p]  = addr[p*AW +: AW];
      portWdata[p] = wdata[p*WIDTH +: WIDTH];
    end
  end

  // Write arbitration: ports are scanned from 0 upward, so the first port to
  // claim an address owns it; any later claimant on the same address is
  // dropped and flags a conflict.
  always_comb begin
    wrHit        = '0;
    conflictNext = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      nextMem[a] = mem[a];
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (wrEn[p]) begin
        if (!wrHit[portAddr[p]]) begin
          wrHit[portAddr[p]]   = 1'b1;
          nextMem[portAddr[p]] = portWdata[p];
        end else begin
          conflictNext = 1'b1;
        end
      end
    end
    // A write to R0 overrides the increment in the same cycle.
    if (ci && !wrHit[0]) begin
      nextMem[0] = mem[0] + WIDTH'(1);
    end
  end

  // Source array for reads: post-edge values with bypass, else current state.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
`ifdef REGFILE_MP_BYPASS_EN
      readView[a] = nextMem[a];
`else
      readView[a] = mem[a];
`endif
    end
  end

  // Carry depends on ci and current R0 only, independent of writes.
  assign co = ci & (&mem[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
      rdata    <= '0;
      rvalid   <= '0;
      conflict <= 1'b0;
      eq       <= 1'b1;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= nextMem[a];
      end
      for (int p = 0; p < NPORTS; p++) begin
        if (rdEn[p]) begin
          rdata[p*WIDTH +: WIDTH] <= readView[portAddr[p]];
        end
      end
      rvalid   <= rdEn;
      conflict <= conflictNext;
      eq       <= (nextMem[0] == nextMem[DEPTH-1]);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Bench for regfile_mp (WIDTH=4, DEPTH=4, NPORTS=4). Directed scenarios
//   followed by randomized traffic, all checked against a word-array model.
//   Follows REGFILE_MP_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int W = 4;
  localparam int D = 4;
  localparam int N = 4;
  localparam int A = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   en;
  logic [N-1:0]   we;
  logic [N-1:0]   re;
  logic [N*A-1:0] addr;
  logic [N*W-1:0] wdata;
  logic [N*W-1:0] rdata;
  logic [N-1:0]   rvalid;
  logic           ci;
  logic           co;
  logic           eq;
  logic           conflict;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NPORTS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .ci       (ci),
    .co       (co),
    .eq       (eq),
    .conflict (conflict)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model + scoreboard ----------------
  logic [W-1:0] mdl    [D];
  logic [W-1:0] lastRd [N];
  logic [W-1:0] exp_q[$];
  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict everything from the model, wait
  // past the edge and compare.
  task automatic cycle(input logic [N-1:0] e, input logic [N-1:0] w,
                       input logic [N-1:0] r, input logic [N*A-1:0] a,
                       input logic [N*W-1:0] d, input logic c, input logic rst);
    logic [W-1:0] nxt [D];
    bit           taken [D];
    bit           expConf;
    logic [N-1:0] expRv;
    int           ad;
    en = e; we = w; re = r; addr = a; wdata = d; ci = c; reset = rst;
    #1;
    check("co", {31'b0, co}, {31'b0, c && (mdl[0] == {W{1'b1}})});

    for (int i = 0; i < D; i++) begin
      nxt[i]   = mdl[i];
      taken[i] = 0;
    end
    expConf = 0;
    for (int p = 0; p < N; p++) begin
      if (e[p] && w[p]) begin
        ad = int'(a[p*A +: A]);
        if (!taken[ad]) begin
          taken[ad] = 1;
          nxt[ad]   = d[p*W +: W];
        end else begin
          expConf = 1;
        end
      end
    end
    if (c && !taken[0]) nxt[0] = W'((int'(mdl[0]) + 1) % (1 << W));

    expRv = '0;
    if (rst) begin
      for (int i = 0; i < D; i++) nxt[i] = '0;
      for (int p = 0; p < N; p++) lastRd[p] = '0;
      expConf = 0;
    end else begin
      for (int p = 0; p < N; p++) begin
        if (e[p] && r[p]) begin
          ad = int'(a[p*A +: A]);
          expRv[p] = 1'b1;
`ifdef REGFILE_MP_BYPASS_EN
          exp_q.push_back(nxt[ad]);
`else
          exp_q.push_back(mdl[ad]);
`endif
        end
      end
    end

    @(posedge clk);
    #1;
    check("rvalid", {28'b0, rvalid}, {28'b0, expRv});
    for (int p = 0; p < N; p++) begin
      if (expRv[p]) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          lastRd[p] = exp_q.pop_front();
        end
      end
      check($sformatf("rdata%0d", p), {28'b0, rdata[p*W +: W]}, {28'b0, lastRd[p]});
    end
    check("conflict", {31'b0, conflict}, {31'b0, expConf});
    check("eq", {31'b0, eq}, {31'b0, nxt[0] == nxt[D-1]});
    for (int i = 0; i < D; i++) mdl[i] = nxt[i];
  endtask

  task automatic idle(input logic c);
    cycle('0, '0, '0, '0, '0, c, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < D; i++) mdl[i] = '0;
    for (int p = 0; p < N; p++) lastRd[p] = '0;
    en = '0; we = '0; re = '0; addr = '0; wdata = '0; ci = 1'b0; reset = 1'b1;

    // Reset, then read every address on its own port.
    cycle('0, '0, '0, '0, '0, 1'b0, 1'b1);
    check("rst_eq", {31'b0, eq}, 32'd1);
    cycle(4'hF, 4'h0, 4'hF, 8'hE4, '0, 1'b0, 1'b0);
    check("rst_read_rvalid", {28'b0, rvalid}, 32'hF);
    check("rst_read_rdata", {16'b0, rdata}, 32'h0);

    // Port 2 writes A to addr 1, port 0 reads it back.
    cycle(4'b0100, 4'b0100, 4'b0000, 8'h10, 16'h0A00, 1'b0, 1'b0);
    cycle(4'b0001, 4'b0000, 4'b0001, 8'h01, '0, 1'b0, 1'b0);
    check("basic_rdata0", {28'b0, rdata[3:0]}, 32'hA);
    check("basic_rvalid", {28'b0, rvalid}, 32'h1);

    // Ports 1 and 3 collide on addr 2; port 1 wins.
    cycle(4'b1010, 4'b1010, 4'b0000, 8'h88, 16'h9050, 1'b0, 1'b0);
    check("conflict_pulse", {31'b0, conflict}, 32'd1);
    cycle(4'b0001, 4'b0000, 4'b0001, 8'h02, '0, 1'b0, 1'b0);
    check("conflict_drop", {31'b0, conflict}, 32'd0);
    check("conflict_winner", {28'b0, rdata[3:0]}, 32'h5);

    // Counter wrap from E, then a write overriding an increment.
    cycle(4'b0001, 4'b0001, 4'b0000, 8'h00, 16'h000E, 1'b0, 1'b0);
    idle(1'b1);
    check("ctr_co_at_F", {31'b0, co}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    cycle(4'b0001, 4'b0001, 4'b0001, 8'h00, 16'h0003, 1'b1, 1'b0);
    cycle(4'b0001, 4'b0000, 4'b0001, 8'h00, '0, 1'b0, 1'b0);
    check("ctr_write_wins", {28'b0, rdata[3:0]}, 32'h3);

    // eq follows R0 vs R3.
    cycle(4'b0001, 4'b0001, 4'b0000, 8'h03, 16'h0007, 1'b0, 1'b0);
    check("eq_fall", {31'b0, eq}, 32'd0);
    cycle(4'b0001, 4'b0001, 4'b0000, 8'h00, 16'h0007, 1'b0, 1'b0);
    check("eq_rise", {31'b0, eq}, 32'd1);

    // Same-cycle write and read of addr 1 holding 2.
    cycle(4'b0001, 4'b0001, 4'b0000, 8'h01, 16'h0002, 1'b0, 1'b0);
    cycle(4'b0011, 4'b0001, 4'b0010, 8'h05, 16'h000C, 1'b0, 1'b0);
`ifdef REGFILE_MP_BYPASS_EN
    check("rw_same_cycle", {28'b0, rdata[7:4]}, 32'hC);
`else
    check("rw_same_cycle", {28'b0, rdata[7:4]}, 32'h2);
`endif

    // Reset in flight: the concurrent read is discarded.
    cycle(4'hF, 4'h0, 4'hF, 8'h1B, '0, 1'b1, 1'b1);
    check("rst_midop_rvalid", {28'b0, rvalid}, 32'h0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      cycle(N'($urandom), N'($urandom), N'($urandom), (N*A)'($urandom),
            (N*W)'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 60) == 0);
    end

    if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multiport register file, the synchronous successor of the 4×4 multiport RAM. Provides DEPTH words of WIDTH bits, accessed by NPORTS independent read/write ports. Register 0 doubles as a cascadable up-counter, and an equality flag compares register 0 with the top register. Sits in the microsequencer/loop-control datapath as a general scratch and counter bank; all data is active-high.

## Interface
- WIDTH, 4, bits per word (≥2)
- DEPTH, 4, number of words (power of two, ≥2); AW = $clog2(DEPTH)
- NPORTS, 4, number of access ports (1..8)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- en  in  NPORTS  port enable, bit p for port p
- we  in  NPORTS  write request, qualified by en[p]
- re  in  NPORTS  read request, qualified by en[p]
- addr  in  NPORTS*AW  port p address in bits [p*AW +: AW]
- wdata  in  NPORTS*WIDTH  port p write data in bits [p*WIDTH +: WIDTH]
- rdata  out  NPORTS*WIDTH  port p registered read data
- rvalid  out  NPORTS  rdata[p] carries the result of a read issued the previous cycle
- ci  in  1  count enable / carry in for register 0
- co  out  1  carry out: ci & (R0 == all ones), combinational
- eq  out  1  registered flag, R0 == R[DEPTH-1]
- conflict  out  1  pulses one cycle after ≥2 ports wrote the same address

## Operation
- Write: port p writes when en[p] & we[p]. The address updates on the next rising edge.
- Multiple writers to one address in one cycle: the lowest-numbered port wins and the others are dropped. conflict is asserted for one cycle on the following cycle.
- Read: port p reads when en[p] & re[p]. rdata[p] gets R[addr_p] on the next edge and rvalid[p]=1.
- Without a read, rdata[p] holds its last value and rvalid[p]=0.
- Reads and writes on the same port in the same cycle are both performed.
- Counter, when ci=1 and no port writes address 0:
  - R0 ← R0+1 modulo 2^WIDTH.
  - Wraps from all ones to 0.
  - co is high during the wrapping cycle.
- Counter vs write: a write to address 0 takes precedence over the increment in the same cycle. co still follows its combinational formula.
- Cascading: connect co of stage k to ci of stage k+1 for wider counters.
- eq is computed from the post-update register values and is registered. It therefore reflects the register state after each edge.
- An address ≥ DEPTH cannot occur because AW is exact.

## Timing
- Reset values: every R[i]=0, rdata=0, rvalid=0, conflict=0, eq=1. co is combinational, so it equals ci when WIDTH bits of R0 are all ones, which is never true immediately after reset.
- Reset dominates all writes, reads and counting in the same cycle. Asserting reset mid-operation discards any in-flight read result: rvalid is 0 the next cycle.
- Read latency is 1 cycle, fully pipelined, with one read per port per cycle.
- Write-to-read through storage:
  - A write at edge N is visible to a read issued in cycle N+1. Data appears at edge N+2.
  - A read and write to the same address in the same cycle returns old data, unless the bypass is compiled in (see Configuration).
- A counter increment at edge N is visible to reads issued in cycle N+1.
- eq and conflict each have 1-cycle latency after the causing edge.

## Configuration
- REGFILE_MP_BYPASS_EN is the compile-in macro.
- Defined: a same-cycle read of an address being written returns the winning (lowest-port) write data. A same-cycle read of R0 while it increments returns the incremented value. Either way the read returns the value R[addr] will hold after the edge.
- Undefined: the read returns the pre-edge contents. This is the default and uses minimum logic.

## Test plan
- Reset then read all: reset 1 cycle; read addresses 0..3 on ports 0..3 -> next cycle rdata=0 on all, rvalid=4'b1111, eq=1, conflict=0.
- Basic write/read: port 2 writes 4'hA to addr 1; next cycle port 0 reads addr 1 -> rdata[0]=4'hA one cycle later, rvalid[0]=1, other rvalid=0.
- Write conflict: ports 1 and 3 write 4'h5 and 4'h9 to addr 2 in the same cycle -> R2=4'h5, conflict=1 for exactly one cycle.
- Counter wrap:
  - Stimulus: write 4'hE to addr 0; hold ci=1 for 3 cycles.
  - R0 sequence: F, 0, 1.
  - co: high only while R0=F.
  - Concurrent write: while counting, write 4'h3 to addr 0 -> R0=3, no increment that cycle.
- eq flag: write 4'h7 to addr 3, then 4'h7 to addr 0 -> eq falls to 0 one cycle after the first write and rises to 1 one cycle after the second.
- Same-cycle read/write: port 0 writes 4'hC to addr 1 while port 1 reads addr 1, old value 4'h2 -> rdata[1]=4'h2 without REGFILE_MP_BYPASS_EN, and 4'hC with it.
